// File: rtl/br_resolve_unit_pkg.sv
// Shared types for the execute-stage branch resolver: bus widths, branch op codes,
// predictor counter states and the resolver FSM states.
package br_resolve_unit_pkg;

    localparam int BRESULT_WD       = 68;
    localparam int BPU_TO_DS_BUS_WD = 36;

    typedef enum logic [3:0] {
        BR_NONE   = 4'd0,
        BR_BEQ    = 4'd1,
        BR_BNE    = 4'd2,
        BR_BGEZ   = 4'd3,
        BR_BGTZ   = 4'd4,
        BR_BLEZ   = 4'd5,
        BR_BLTZ   = 4'd6,
        BR_BGEZAL = 4'd7,
        BR_BLTZAL = 4'd8,
        BR_J      = 4'd9,
        BR_JAL    = 4'd10,
        BR_JR     = 4'd11,
        BR_JALR   = 4'd12
    } br_op_e;

    typedef enum logic [1:0] {
        CNT_WT  = 2'b00,
        CNT_ST  = 2'b01,
        CNT_WNT = 2'b10,
        CNT_SNT = 2'b11
    } cnt_state_e;

    typedef struct packed {
        logic        is_taken;
        logic [1:0]  count;
        logic        hit;
        logic [31:0] pred_target;
    } bpu_pred_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_DS = 2'd1,
        ST_SQUASH  = 2'd2
    } br_state_e;

endpackage

// File: rtl/br_resolve_unit_cond_eval.sv
// Combinational branch evaluation: taken decision, branch/jump target and the
// correct next fetch address (target if taken, otherwise past the delay slot).
module br_resolve_unit_cond_eval
    import br_resolve_unit_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [3:0]  i_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    input  logic [15:0] i_imm16,
    input  logic [25:0] i_instr_index,
    output logic        o_taken,
    output logic [31:0] o_target,
    output logic [31:0] o_next_pc
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic        w_rs_zero;

    assign w_pc_plus4  = i_pc + 32'd4;
    assign w_br_target = w_pc_plus4 + {{14{i_imm16[15]}}, i_imm16, 2'b00};
    assign w_j_target  = {w_pc_plus4[31:28], i_instr_index, 2'b00};
    assign w_rs_zero   = (i_rs == 32'd0);

    always_comb begin
        o_taken  = 1'b0;
        o_target = w_br_target;
        case (i_op)
            BR_BEQ:              o_taken = (i_rs == i_rt);
            BR_BNE:              o_taken = (i_rs != i_rt);
            BR_BGEZ, BR_BGEZAL:  o_taken = ~i_rs[31];
            BR_BGTZ:             o_taken = ~i_rs[31] & ~w_rs_zero;
            BR_BLEZ:             o_taken = i_rs[31] | w_rs_zero;
            BR_BLTZ, BR_BLTZAL:  o_taken = i_rs[31];
            BR_J, BR_JAL: begin
                o_taken  = 1'b1;
                o_target = w_j_target;
            end
            BR_JR, BR_JALR: begin
                o_taken  = 1'b1;
                o_target = i_rs;
            end
            default: begin
                o_taken  = 1'b0;
                o_target = w_br_target;
            end
        endcase
    end

    assign o_next_pc = o_taken ? o_target : (i_pc + 32'd8);

endmodule

// File: rtl/br_resolve_unit.sv
// Execute-stage branch resolver: produces the registered BResult predictor update,
// redirects fetch on mispredict and squashes wrong-path work until the target arrives.
module br_resolve_unit
    import br_resolve_unit_pkg::*;
#(
    parameter int         CNT_WIDTH  = 32,
    parameter logic [1:0] INIT_COUNT = CNT_WNT
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        es_valid,
    input  logic                        es_fire,
    input  logic [31:0]                 es_pc,
    input  logic [3:0]                  es_br_op,
    input  logic [31:0]                 es_rs_value,
    input  logic [31:0]                 es_rt_value,
    input  logic [15:0]                 es_imm16,
    input  logic [25:0]                 es_instr_index,
    input  logic [BPU_TO_DS_BUS_WD-1:0] es_pred_bus,
    input  logic                        ws_flush,
    input  logic                        fs_redirect_ack,
    output logic [BRESULT_WD-1:0]       BResult,
    output logic                        br_redirect,
    output logic [31:0]                 br_redirect_target,
    output logic                        es_squash,
    output logic [CNT_WIDTH-1:0]        perf_br_cnt,
    output logic [CNT_WIDTH-1:0]        perf_mis_cnt
);

    bpu_pred_t             w_pred;
    logic                  w_taken;
    logic [31:0]           w_target;
    logic [31:0]           w_next_pc;
    logic                  w_fire;
    logic                  w_squash;
    logic                  w_is_branch;
    logic                  w_mispredict;
    logic                  w_mis_count;
    logic [1:0]            w_old_count;
    br_state_e             r_state;
    br_state_e             w_state_nxt;
    logic                  r_redirect_pending;
    logic [31:0]           r_red_tgt;
    logic [BRESULT_WD-1:0] r_bresult;
    logic [CNT_WIDTH-1:0]  r_br_cnt;
    logic [CNT_WIDTH-1:0]  r_mis_cnt;

    br_resolve_unit_cond_eval u_cond_eval (
        .i_pc          (es_pc),
        .i_op          (es_br_op),
        .i_rs          (es_rs_value),
        .i_rt          (es_rt_value),
        .i_imm16       (es_imm16),
        .i_instr_index (es_instr_index),
        .o_taken       (w_taken),
        .o_target      (w_target),
        .o_next_pc     (w_next_pc)
    );

    assign w_pred      = es_pred_bus;
    assign w_fire      = es_fire & es_valid;
    assign w_squash    = (r_state == ST_SQUASH) & es_valid & (es_pc != r_red_tgt);
    assign w_is_branch = w_fire & (es_br_op != 4'd0) & ~w_squash & ~ws_flush;
    assign w_old_count = w_pred.hit ? w_pred.count : INIT_COUNT;

    assign w_mispredict = (~w_pred.hit & w_taken)
                        | (w_pred.hit & (w_pred.is_taken != w_taken))
                        | (w_pred.hit & w_taken & (w_pred.pred_target != w_target));

    // A branch sitting in a delay slot cannot start a second redirect.
    assign w_mis_count = w_is_branch & w_mispredict & (r_state != ST_WAIT_DS);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_mis_count) w_state_nxt = ST_WAIT_DS;
            end
            ST_WAIT_DS: begin
                if (w_fire) w_state_nxt = ST_SQUASH;
            end
            ST_SQUASH: begin
                if (w_fire && !w_squash) w_state_nxt = w_mis_count ? ST_WAIT_DS : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (ws_flush) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_redirect_pending <= 1'b0;
            r_red_tgt          <= 32'd0;
        end else if (w_mis_count) begin
            r_redirect_pending <= 1'b1;
            r_red_tgt          <= w_next_pc;
        end else if (ws_flush || fs_redirect_ack) begin
            r_redirect_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bresult <= '0;
        end else if (w_is_branch) begin
            r_bresult <= {es_pc, w_old_count, 1'b1, w_taken, w_target};
        end else begin
            r_bresult <= '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_br_cnt  <= '0;
            r_mis_cnt <= '0;
        end else begin
            if (w_is_branch && (r_br_cnt != '1)) r_br_cnt <= r_br_cnt + CNT_WIDTH'(1);
            if (w_mis_count && (r_mis_cnt != '1)) r_mis_cnt <= r_mis_cnt + CNT_WIDTH'(1);
        end
    end

    assign BResult            = r_bresult;
    assign br_redirect        = r_redirect_pending;
    assign br_redirect_target = r_red_tgt;
    assign es_squash          = w_squash;
    assign perf_br_cnt        = r_br_cnt;
    assign perf_mis_cnt       = r_mis_cnt;

endmodule

// File: tb/tb_br_resolve_unit.sv
// Bench for br_resolve_unit: vector table through a BResult scoreboard, then
// hand-built redirect/squash, flush and asynchronous-reset sequences.
module tb_br_resolve_unit;

    localparam int CW = 4;
    localparam int NV = 15;

    logic          clk;
    logic          resetn;
    logic          es_valid;
    logic          es_fire;
    logic [31:0]   es_pc;
    logic [3:0]    es_br_op;
    logic [31:0]   es_rs_value;
    logic [31:0]   es_rt_value;
    logic [15:0]   es_imm16;
    logic [25:0]   es_instr_index;
    logic [35:0]   es_pred_bus;
    logic          ws_flush;
    logic          fs_redirect_ack;
    logic [67:0]   BResult;
    logic          br_redirect;
    logic [31:0]   br_redirect_target;
    logic          es_squash;
    logic [CW-1:0] perf_br_cnt;
    logic [CW-1:0] perf_mis_cnt;

    br_resolve_unit #(.CNT_WIDTH(CW), .INIT_COUNT(2'b10)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .es_valid           (es_valid),
        .es_fire            (es_fire),
        .es_pc              (es_pc),
        .es_br_op           (es_br_op),
        .es_rs_value        (es_rs_value),
        .es_rt_value        (es_rt_value),
        .es_imm16           (es_imm16),
        .es_instr_index     (es_instr_index),
        .es_pred_bus        (es_pred_bus),
        .ws_flush           (ws_flush),
        .fs_redirect_ack    (fs_redirect_ack),
        .BResult            (BResult),
        .br_redirect        (br_redirect),
        .br_redirect_target (br_redirect_target),
        .es_squash          (es_squash),
        .perf_br_cnt        (perf_br_cnt),
        .perf_mis_cnt       (perf_mis_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [35:0] pred;
        logic        expBr;
        logic        expTaken;
        logic [31:0] expTarget;
        logic [1:0]  expCnt;
        logic        expMis;
        logic [31:0] expRedir;
    } vec_t;

    vec_t        vecs [NV];
    logic [67:0] expQ [$];
    logic [CW-1:0] brExp;
    logic [CW-1:0] misExp;
    int          checkCount;
    int          passCount;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [35:0] mkPred(input logic isT, input logic [1:0] cnt,
                                           input logic hit, input logic [31:0] tgt);
        return {isT, cnt, hit, tgt};
    endfunction

    function automatic logic [67:0] mkRes(input logic [31:0] pc, input logic [1:0] cnt,
                                          input logic taken, input logic [31:0] tgt);
        return {pc, cnt, 1'b1, taken, tgt};
    endfunction

    function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    task automatic compare(input string name, input logic [67:0] act, input logic [67:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic fire, input logic [31:0] pc, input logic [3:0] op,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [15:0] imm, input logic [25:0] idx,
                                 input logic [35:0] pred, input logic flush, input logic ack,
                                 input logic expSquash, input logic [67:0] expRes);
        es_valid        = fire;
        es_fire         = fire;
        es_pc           = pc;
        es_br_op        = op;
        es_rs_value     = rs;
        es_rt_value     = rt;
        es_imm16        = imm;
        es_instr_index  = idx;
        es_pred_bus     = pred;
        ws_flush        = flush;
        fs_redirect_ack = ack;
        expQ.push_back(expRes);
        #3;
        compare("es_squash", {67'd0, es_squash}, {67'd0, expSquash});
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input logic expRedir, input logic [31:0] expTgt);
        logic [67:0] exp;
        if (expQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL scoreboard: no expected BResult queued");
        end else begin
            exp = expQ.pop_front();
            compare("BResult", BResult, exp);
        end
        compare("br_redirect", {67'd0, br_redirect}, {67'd0, expRedir});
        if (expRedir) compare("br_redirect_target", {36'd0, br_redirect_target}, {36'd0, expTgt});
        compare("perf_br_cnt", {{(68-CW){1'b0}}, perf_br_cnt}, {{(68-CW){1'b0}}, brExp});
        compare("perf_mis_cnt", {{(68-CW){1'b0}}, perf_mis_cnt}, {{(68-CW){1'b0}}, misExp});
    endtask

    task automatic idleCycle(input logic flush, input logic ack);
        applyStimulus(1'b0, 32'd0, 4'd0, 32'd0, 32'd0, 16'd0, 26'd0, 36'd0, flush, ack, 1'b0, 68'd0);
    endtask

    initial begin
        logic [67:0] res;
        checkCount = 0;
        passCount  = 0;
        brExp      = '0;
        misExp     = '0;

        //              pc            op     rs            rt     imm       idx          pred                                br tk tgt            cnt    mis redir
        vecs[0]  = '{32'hBFC00100, 4'd1,  32'd5,        32'd5, 16'h0004, 26'd0,       mkPred(1, 2'b01, 1, 32'hBFC00114), 1, 1, 32'hBFC00114, 2'b01, 0, 32'd0};
        vecs[1]  = '{32'h00400000, 4'd2,  32'd7,        32'd7, 16'h0010, 26'd0,       mkPred(0, 2'b00, 0, 32'd0),        1, 0, 32'h00400044, 2'b10, 0, 32'd0};
        vecs[2]  = '{32'h00001000, 4'd3,  32'hFFFFFFFF, 32'd0, 16'hFFFF, 26'd0,       mkPred(0, 2'b11, 1, 32'd0),        1, 0, 32'h00001000, 2'b11, 0, 32'd0};
        vecs[3]  = '{32'h00002000, 4'd4,  32'd0,        32'd0, 16'h0002, 26'd0,       mkPred(1, 2'b00, 1, 32'h0000200C), 1, 0, 32'h0000200C, 2'b00, 1, 32'h00002008};
        vecs[4]  = '{32'h00003000, 4'd5,  32'd0,        32'd0, 16'h0003, 26'd0,       mkPred(1, 2'b01, 1, 32'h00003010), 1, 1, 32'h00003010, 2'b01, 0, 32'd0};
        vecs[5]  = '{32'h00004000, 4'd6,  32'h80000000, 32'd0, 16'h8000, 26'd0,       mkPred(1, 2'b01, 1, 32'hFFFE4000), 1, 1, 32'hFFFE4004, 2'b01, 1, 32'hFFFE4004};
        vecs[6]  = '{32'h00005000, 4'd7,  32'd1,        32'd0, 16'h0001, 26'd0,       mkPred(0, 2'b00, 0, 32'd0),        1, 1, 32'h00005008, 2'b10, 1, 32'h00005008};
        vecs[7]  = '{32'h00006000, 4'd8,  32'd1,        32'd0, 16'h0001, 26'd0,       mkPred(0, 2'b00, 0, 32'd0),        1, 0, 32'h00006008, 2'b10, 0, 32'd0};
        vecs[8]  = '{32'h80001000, 4'd9,  32'd0,        32'd0, 16'h0000, 26'h0000400, mkPred(0, 2'b00, 0, 32'd0),        1, 1, 32'h80001000, 2'b10, 1, 32'h80001000};
        vecs[9]  = '{32'h9FFFFFFC, 4'd10, 32'd0,        32'd0, 16'h0000, 26'h3FFFFFF, mkPred(1, 2'b00, 1, 32'hAFFFFFFC), 1, 1, 32'hAFFFFFFC, 2'b00, 0, 32'd0};
        vecs[10] = '{32'h00007000, 4'd11, 32'h00002000, 32'd0, 16'h0000, 26'd0,       mkPred(1, 2'b00, 1, 32'h00001000), 1, 1, 32'h00002000, 2'b00, 1, 32'h00002000};
        vecs[11] = '{32'h00008000, 4'd12, 32'h12345678, 32'd0, 16'h0000, 26'd0,       mkPred(1, 2'b01, 1, 32'h12345678), 1, 1, 32'h12345678, 2'b01, 0, 32'd0};
        vecs[12] = '{32'h00000100, 4'd4,  32'h7FFFFFFF, 32'd0, 16'h0000, 26'd0,       mkPred(0, 2'b10, 1, 32'd0),        1, 1, 32'h00000104, 2'b10, 1, 32'h00000104};
        vecs[13] = '{32'h00009000, 4'd0,  32'd0,        32'd0, 16'h0000, 26'd0,       mkPred(0, 2'b00, 0, 32'd0),        0, 0, 32'd0,        2'b00, 0, 32'd0};
        vecs[14] = '{32'h0000A000, 4'd5,  32'h80000000, 32'd0, 16'h0001, 26'd0,       mkPred(1, 2'b00, 1, 32'h0000A008), 1, 1, 32'h0000A008, 2'b00, 0, 32'd0};

        resetn = 1'b0;
        es_valid = 1'b0; es_fire = 1'b0; es_pc = '0; es_br_op = '0;
        es_rs_value = '0; es_rt_value = '0; es_imm16 = '0; es_instr_index = '0;
        es_pred_bus = '0; ws_flush = 1'b0; fs_redirect_ack = 1'b0;
        #12;
        compare("reset BResult", BResult, 68'd0);
        compare("reset br_redirect", {67'd0, br_redirect}, 68'd0);
        compare("reset es_squash", {67'd0, es_squash}, 68'd0);
        compare("reset perf_br_cnt", {{(68-CW){1'b0}}, perf_br_cnt}, 68'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            res = vecs[i].expBr ? mkRes(vecs[i].pc, vecs[i].expCnt, vecs[i].expTaken, vecs[i].expTarget) : 68'd0;
            if (vecs[i].expBr) brExp = satInc(brExp);
            if (vecs[i].expMis) misExp = satInc(misExp);
            applyStimulus(1'b1, vecs[i].pc, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].imm,
                          vecs[i].idx, vecs[i].pred, 1'b0, 1'b0, 1'b0, res);
            checkOutput(vecs[i].expMis, vecs[i].expRedir);
            idleCycle(1'b1, 1'b0);
            checkOutput(1'b0, 32'd0);
        end

        // J mispredict: redirect held until ack, delay slot kept, wrong path squashed.
        brExp  = satInc(brExp);
        misExp = satInc(misExp);
        applyStimulus(1'b1, 32'h80001000, 4'd9, 32'd0, 32'd0, 16'd0, 26'h0000400,
                      mkPred(0, 2'b00, 0, 32'd0), 1'b0, 1'b0, 1'b0,
                      mkRes(32'h80001000, 2'b10, 1'b1, 32'h80001000));
        checkOutput(1'b1, 32'h80001000);
        for (int k = 0; k < 3; k++) begin
            idleCycle(1'b0, 1'b0);
            checkOutput(1'b1, 32'h80001000);
        end
        idleCycle(1'b0, 1'b1);
        checkOutput(1'b0, 32'd0);
        applyStimulus(1'b1, 32'h80001004, 4'd0, 32'd0, 32'd0, 16'd0, 26'd0, 36'd0, 1'b0, 1'b0, 1'b0, 68'd0);
        checkOutput(1'b0, 32'd0);
        applyStimulus(1'b1, 32'h80001008, 4'd0, 32'd0, 32'd0, 16'd0, 26'd0, 36'd0, 1'b0, 1'b0, 1'b1, 68'd0);
        checkOutput(1'b0, 32'd0);
        applyStimulus(1'b1, 32'h8000100C, 4'd1, 32'd3, 32'd3, 16'd0, 26'd0,
                      mkPred(0, 2'b00, 0, 32'd0), 1'b0, 1'b0, 1'b1, 68'd0);
        checkOutput(1'b0, 32'd0);
        brExp = satInc(brExp);
        applyStimulus(1'b1, 32'h80001000, 4'd1, 32'd3, 32'd3, 16'd0, 26'd0,
                      mkPred(1, 2'b01, 1, 32'h80001004), 1'b0, 1'b0, 1'b0,
                      mkRes(32'h80001000, 2'b01, 1'b1, 32'h80001004));
        checkOutput(1'b0, 32'd0);
        applyStimulus(1'b1, 32'h00000040, 4'd0, 32'd0, 32'd0, 16'd0, 26'd0, 36'd0, 1'b0, 1'b0, 1'b0, 68'd0);
        checkOutput(1'b0, 32'd0);

        // Flush wins over a simultaneous mispredict.
        applyStimulus(1'b1, 32'h00007000, 4'd11, 32'h00002000, 32'd0, 16'd0, 26'd0,
                      mkPred(1, 2'b00, 1, 32'h00001000), 1'b1, 1'b0, 1'b0, 68'd0);
        checkOutput(1'b0, 32'd0);
        applyStimulus(1'b1, 32'h00000044, 4'd0, 32'd0, 32'd0, 16'd0, 26'd0, 36'd0, 1'b0, 1'b0, 1'b0, 68'd0);
        checkOutput(1'b0, 32'd0);

        // Asynchronous reset while squashing with a redirect outstanding.
        misExp = satInc(misExp);
        brExp  = satInc(brExp);
        applyStimulus(1'b1, 32'h80001000, 4'd9, 32'd0, 32'd0, 16'd0, 26'h0000400,
                      mkPred(0, 2'b00, 0, 32'd0), 1'b0, 1'b0, 1'b0,
                      mkRes(32'h80001000, 2'b10, 1'b1, 32'h80001000));
        checkOutput(1'b1, 32'h80001000);
        brExp = satInc(brExp);
        applyStimulus(1'b1, 32'h80001004, 4'd1, 32'd0, 32'd0, 16'd0, 26'd0,
                      mkPred(1, 2'b01, 1, 32'h80001008), 1'b0, 1'b0, 1'b0,
                      mkRes(32'h80001004, 2'b01, 1'b1, 32'h80001008));
        checkOutput(1'b1, 32'h80001000);
        es_valid = 1'b1;
        es_fire  = 1'b1;
        es_pc    = 32'h00000500;
        es_br_op = 4'd0;
        #2;
        compare("squash before reset", {67'd0, es_squash}, 68'd1);
        resetn = 1'b0;
        #1;
        compare("async reset BResult", BResult, 68'd0);
        compare("async reset br_redirect", {67'd0, br_redirect}, 68'd0);
        compare("async reset es_squash", {67'd0, es_squash}, 68'd0);
        compare("async reset perf_br_cnt", {{(68-CW){1'b0}}, perf_br_cnt}, 68'd0);
        compare("async reset perf_mis_cnt", {{(68-CW){1'b0}}, perf_mis_cnt}, 68'd0);
        es_valid = 1'b0;
        es_fire  = 1'b0;
        @(posedge clk);
        #2;
        resetn = 1'b1;
        compare("post reset br_redirect", {67'd0, br_redirect}, 68'd0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/br_resolve_unit.md
Name: br_resolve_unit

Overview:
Execute-stage branch resolver; producer end of the BResult bus consumed by the branch predictor.
- Evaluates each branch/jump on its execute-stage fire and compares the outcome against the prediction carried down from decode (BPU_to_ds_bus format).
- Emits the registered BResult update, drives a fetch redirect on mispredict and squashes wrong-path instructions until the correct path arrives.
- Keeps branch and mispredict performance counters.

Parameters:
CNT_WIDTH, 32, width of performance counters
INIT_COUNT, 2'b10, counter value reported as "old" on predictor miss (weak not-taken)

Ports:
clk  in  1  clock
resetn  in  1  reset
es_valid  in  1  execute-stage instruction valid
es_fire  in  1  es_valid & es_ready_go & ms_allowin; instruction leaves ES this cycle
es_pc  in  32  instruction PC
es_br_op  in  4  0 none, 1 BEQ, 2 BNE, 3 BGEZ, 4 BGTZ, 5 BLEZ, 6 BLTZ, 7 BGEZAL, 8 BLTZAL, 9 J, 10 JAL, 11 JR, 12 JALR
es_rs_value  in  32  forwarded rs
es_rt_value  in  32  forwarded rt
es_imm16  in  16  branch offset field
es_instr_index  in  26  J/JAL index field
es_pred_bus  in  36  {is_taken, count[1:0], hit, pred_target[31:0]}
ws_flush  in  1  exception/ERET flush
fs_redirect_ack  in  1  fetch accepted the redirect this cycle
BResult  out  68  {pc[31:0], old_count[1:0], is_branch, taken, target[31:0]}, registered
br_redirect  out  1  redirect request to fetch
br_redirect_target  out  32  correct next-fetch address
es_squash  out  1  current ES instruction is wrong-path; downstream must drop it
perf_br_cnt  out  CNT_WIDTH  resolved branches
perf_mis_cnt  out  CNT_WIDTH  mispredicts

Behaviour:
Clock/reset: one clock clk; reset resetn is asynchronous and active-low. Reset clears all outputs and state to 0, FSM to IDLE.

Resolution is combinational from ES inputs:
- taken: BEQ rs==rt; BNE rs!=rt; BGEZ/BGEZAL rs[31]==0; BGTZ signed rs>0; BLEZ signed rs<=0; BLTZ/BLTZAL rs[31]==1; ops 9-12 always taken.
- target: cond branches = es_pc+4+{{14{imm[15]}},imm,2'b00}; J/JAL = {pc_plus4[31:28],index,2'b00}; JR/JALR = rs.
- next_pc = taken ? target : es_pc+8.
- mispredict when any of:
  - hit=0 and taken;
  - hit=1 and is_taken!=taken;
  - hit=1, taken, and pred_target!=target.

BResult (registered one cycle after fire):
- is_branch = es_fire & br_op!=0 & ~es_squash & ~ws_flush.
- old_count = hit ? count : INIT_COUNT.
- target field always carries the computed target, even when not taken.
- When is_branch=0, the whole bus is 0 (the predictor must see no write).

FSM, one of IDLE / WAIT_DS / SQUASH:
- IDLE: a counted mispredict loads red_tgt<=next_pc, sets redirect_pending, goes to WAIT_DS.
- WAIT_DS: the next fire is the delay slot; it is not squashed. Go to SQUASH.
- SQUASH:
  - A fire with es_pc==red_tgt returns to IDLE and is processed normally, including as a branch.
  - Other fires assert es_squash and produce no BResult, no counters and no redirect.
- ws_flush in any state: go to IDLE, clear redirect_pending, suppress that cycle's BResult. Flush has priority over a simultaneous mispredict.

Redirect:
- br_redirect = redirect_pending; held stable with its target until a cycle with fs_redirect_ack=1, cleared the next edge.
- ack and a new mispredict cannot coincide (the new mispredict is squashed).

Counters:
- perf_br_cnt increments on each is_branch; perf_mis_cnt on each counted mispredict.
- Both saturate at all-ones. Asynchronous reset clears them.

Decomposition:
- global_defines.vh holds BRESULT_WD (68), BPU_TO_DS_BUS_WD (36), br_op encodings and counter-state encodings (00 weak-taken, 01 strong-taken, 10 weak-not-taken, 11 strong-not-taken).
- One sub-module is natural: br_cond_eval, the combinational taken/target/next_pc computation.

Test Plan:
- BEQ at pc 0xBFC00100, rs=rt=5, imm=0x0004, pred hit taken, target 0xBFC00114 -> no redirect; next cycle BResult={0xBFC00100,count,1,1,0xBFC00114}; perf_br_cnt=1.
- BNE with rs=rt, pred miss -> not taken, no redirect; BResult old_count=2'b10, taken=0.
- J at 0x80001000, index=0x0000400, pred miss -> br_redirect=1, target 0x80001000; held 3 cycles until ack; delay slot fire not squashed; next two fires at pc!=target squashed; fire at 0x80001000 returns to IDLE; perf_mis_cnt=1.
- JR with hit, taken, pred_target 0x1000, rs=0x2000 -> mispredict, redirect 0x2000.
- ws_flush asserted in the same cycle as a mispredicting fire -> no redirect, BResult zero, FSM IDLE.
- resetn pulled low while in SQUASH with redirect pending -> br_redirect, es_squash, BResult and counters all 0 immediately, without waiting for a clock edge.
